// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single SOPC memory port between the instruction-fetch path (i_*)
// and the load/store path (d_*). Transactions are serialised onto the slave
// port (m_*). A pipeline stall is requested while either side is still waiting
// for its ack. Slave accesses that hang are aborted after TIMEOUT cycles.
//
// Handshake (all three ports): the requester raises req with stable fields and
// holds it until it sees a one-cycle ack. On the slave port, m_req is held
// until m_ack or a timeout abort. err qualifies ack and flags a timed-out access.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_req, i_addr                fetch request and address
//   i_rdata, i_ack, i_err        fetch response
//   d_req, d_we, d_sel           data request, write enable, byte enables
//   d_addr, d_wdata              data address and write data
//   d_rdata, d_ack, d_err        data response
//   m_req, m_we, m_sel           slave request and registered granted fields
//   m_addr, m_wdata
//   m_rdata, m_ack               slave response
//   stall_req                    pipeline stall while any access is outstanding
module mem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_D_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                d_err,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_sel,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  output logic                stall_req
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RUN_W = $clog2(MAX_D_RUN + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_D_RUN);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t           state, state_d;
  logic [TMO_W-1:0] tmo;
  logic [RUN_W-1:0] d_run;
  logic             grant_i, grant_d;
  logic             done_ok, done_tmo;

  assign stall_req = (i_req & ~i_ack) | (d_req & ~d_ack);

  // Next state and per-cycle decisions. m_ack outside BUSY_x is ignored.
  always_comb begin
    state_d  = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    case (state)
      IDLE: begin
        // Data wins a tie unless it has already won MAX_D_RUN in a row
        // while the fetch side was waiting.
        if (i_req && d_req) begin
          if (d_run == RUN_MAX) grant_i = 1'b1;
          else                  grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i) state_d = BUSY_I;
        if (grant_d) state_d = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        // An ack arriving in the last allowed cycle still completes normally.
        if (m_ack)                done_ok  = 1'b1;
        else if (tmo == TMO_LAST) done_tmo = 1'b1;
        if (done_ok || done_tmo) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_sel   <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      i_err   <= 1'b0;
      i_rdata <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
      d_run   <= '0;
      tmo     <= '0;
    end else begin
      if (grant_i) begin
        // A fetch is always a full-word read.
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_sel   <= '1;
        m_addr  <= i_addr;
        m_wdata <= '0;
        tmo     <= '0;
        d_run   <= '0;
      end else if (grant_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_sel   <= d_sel;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        tmo     <= '0;
        if (!i_req)                d_run <= '0;
        else if (d_run != RUN_MAX) d_run <= d_run + RUN_W'(1);
      end

      if (done_ok || done_tmo) begin
        m_req <= 1'b0;
        tmo   <= '0;
        if (state == BUSY_I) begin
          i_ack   <= 1'b1;
          i_err   <= done_tmo;
          i_rdata <= done_ok ? m_rdata : '0;
        end else begin
          d_ack   <= 1'b1;
          d_err   <= done_tmo;
          d_rdata <= (done_ok && !m_we) ? m_rdata : '0;
        end
      end else if (state == BUSY_I || state == BUSY_D) begin
        tmo <= tmo + TMO_W'(1);
      end

      if (state == RESP) begin
        i_ack <= 1'b0;
        i_err <= 1'b0;
        d_ack <= 1'b0;
        d_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter (TIMEOUT=8, MAX_D_RUN=4).
// Requester driver tasks, a slave responder with configurable latency, and a
// scoreboard: expected grants and responses are queued when stimulus is driven
// and popped when the DUT raises m_req or an ack.
module tb_mem_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack, i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack, d_err;
  logic        m_req, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        stall_req;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .MAX_D_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .stall_req(stall_req)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // grant entry: {is_d, we, sel[3:0], addr[31:0], wdata[31:0]}
  logic [69:0] grant_q[$];
  // response entry: {is_d, err, rdata[31:0]}
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h4) ? 32'h3401_1100 : ((a ^ 32'hA5A5_0000) + 32'h1357);
  endfunction

  task automatic push_grant(input logic is_d, input logic we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata);
    grant_q.push_back({is_d, we, sel, addr, wdata});
  endtask

  task automatic push_txn(input logic is_d, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic err);
    logic [31:0] rd;
    push_grant(is_d, we, sel, addr, wdata);
    rd = (err || we) ? 32'h0 : mem_fn(addr);
    exp_q.push_back({is_d, err, rd});
  endtask

  // Response monitor: compare every ack against the head of exp_q.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && i_ack) begin
      check("ack_expected_i", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_i", 64'({1'b0, i_err, i_rdata}), 64'(e));
      end
    end
    if (!rst && d_ack) begin
      check("ack_expected_d", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_d", 64'({1'b1, d_err, d_rdata}), 64'(e));
      end
    end
  end

  // ---------------- slave responder ----------------
  int busy_cyc = 0;
  int last_run = 0;
  int slv_lat  = 0;
  int slv_fix  = 0;   // fixed latency, -1 = never ack
  bit slv_rand = 1'b0;
  bit spur     = 1'b0;

  initial begin
    logic [69:0] g;
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      if (m_req) begin
        if (busy_cyc == 0) begin
          slv_lat = slv_rand ? int'($urandom_range(0, 3)) : slv_fix;
          check("grant_expected", 64'(grant_q.size() != 0), 64'(1));
          if (grant_q.size() != 0) begin
            g = grant_q.pop_front();
            check("grant_addr", 64'(m_addr), 64'(g[63:32]));
            check("grant_we", 64'(m_we), 64'(g[68]));
            if (g[69]) check("grant_d_sel_wdata", 64'({m_sel, m_wdata}), 64'({g[67:64], g[31:0]}));
          end
        end
        if (busy_cyc == slv_lat) begin
          m_ack   = 1'b1;
          m_rdata = mem_fn(m_addr);
        end
        busy_cyc++;
      end else begin
        if (busy_cyc > 0) last_run = busy_cyc;
        busy_cyc = 0;
        if (spur) begin
          m_ack   = 1'b1;
          m_rdata = 32'hFFFF_FFFF;
          spur    = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input bit is_d);
    int t = 0;
    while (!(is_d ? d_ack : i_ack) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(is_d ? "ack_wait_d" : "ack_wait_i", 64'(is_d ? d_ack : i_ack), 64'(1));
  endtask

  // Holds i_req for n back-to-back fetches, stepping the address by 4.
  task automatic i_txn(input int n, input logic [31:0] addr);
    i_req  = 1'b1;
    i_addr = addr;
    for (int j = 0; j < n; j++) begin
      wait_ack(1'b0);
      @(posedge clk); #1;
      i_addr = i_addr + 32'd4;
    end
    i_req = 1'b0;
  endtask

  task automatic d_txn(input int n, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_sel = sel;
    for (int j = 0; j < n; j++) begin
      wait_ack(1'b1);
      @(posedge clk); #1;
      d_addr = d_addr + 32'd4;
    end
    d_req = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_m_req"}, 64'(m_req), 64'(0));
    check({tag, "_m_fields"}, 64'({m_we, m_sel, m_addr, m_wdata}), 64'(0));
    check({tag, "_acks"}, 64'({i_ack, i_err, d_ack, d_err}), 64'(0));
    check({tag, "_i_rdata"}, 64'(i_rdata), 64'(0));
    check({tag, "_d_rdata"}, 64'(d_rdata), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    check("reset_stall", 64'(stall_req), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch, slave acks with k=0.
    push_txn(1'b0, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
    i_req = 1'b1; i_addr = 32'h4;                        // cycle 0
    #1;
    check("t1_stall_c0", 64'(stall_req), 64'(1));
    @(posedge clk); #1;                                  // cycle 1
    check("t1_mreq_c1", 64'({m_req, i_ack}), 64'({1'b1, 1'b0}));
    @(posedge clk); #1;                                  // cycle 2
    check("t1_mreq_c2", 64'(m_req), 64'(0));
    check("t1_ack_c2", 64'({i_ack, i_rdata}), 64'({1'b1, 32'h3401_1100}));
    @(posedge clk); #1;                                  // cycle 3
    i_req = 1'b0;
    #1;
    check("t1_stall_c3", 64'({stall_req, i_ack}), 64'(0));

    // Simultaneous requests: D write first, then I.
    slv_rand = 1'b1;
    push_txn(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
    push_txn(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
    fork
      d_txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      i_txn(1, 32'h20);
    join
    check("t2_d_rdata", 64'(d_rdata), 64'(0));

    // Starvation guard: 4 D, 1 I, 4 D, 1 I, 1 D.
    for (int j = 0; j < 4; j++) push_txn(1'b1, 1'b0, 4'h3, 32'h100 + 32'(4 * j), 32'h55, 1'b0);
    push_txn(1'b0, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0);
    for (int j = 4; j < 8; j++) push_txn(1'b1, 1'b0, 4'h3, 32'h100 + 32'(4 * j), 32'h55, 1'b0);
    push_txn(1'b0, 1'b0, 4'hF, 32'h204, 32'h0, 1'b0);
    push_txn(1'b1, 1'b0, 4'h3, 32'h120, 32'h55, 1'b0);
    fork
      d_txn(9, 1'b0, 32'h100, 32'h55, 4'h3);
      i_txn(2, 32'h200);
    join

    // Timeout: slave never acks a D read.
    slv_rand = 1'b0;
    slv_fix  = -1;
    push_txn(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1);
    d_txn(1, 1'b0, 32'h40, 32'h0, 4'hF);
    check("t4_mreq_cycles", 64'(last_run), 64'(8));
    check("t4_d_rdata", 64'(d_rdata), 64'(0));
    slv_fix = 0;
    push_txn(1'b0, 1'b0, 4'hF, 32'h44, 32'h0, 1'b0);
    i_txn(1, 32'h44);

    // Boundary: ack in the 8th BUSY cycle completes normally.
    slv_fix = 7;
    push_txn(1'b1, 1'b0, 4'hF, 32'h60, 32'h0, 1'b0);
    d_txn(1, 1'b0, 32'h60, 32'h0, 4'hF);
    check("t5_mreq_cycles", 64'(last_run), 64'(8));

    // Spurious m_ack in IDLE is ignored; rdata holds.
    slv_fix = 0;
    spur    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5_spur_quiet", 64'({m_req, i_ack, d_ack}), 64'(0));
    check("t5_d_rdata_hold", 64'(d_rdata), 64'(mem_fn(32'h60)));
    check("t5_i_rdata_hold", 64'(i_rdata), 64'(mem_fn(32'h44)));
    push_txn(1'b0, 1'b0, 4'hF, 32'h64, 32'h0, 1'b0);
    i_txn(1, 32'h64);

    // Reset while BUSY: outputs drop without a clock, then I is re-granted.
    slv_fix = -1;
    push_grant(1'b0, 1'b0, 4'hF, 32'h80, 32'h0);
    i_req = 1'b1; i_addr = 32'h80;
    repeat (3) @(posedge clk);
    #1;
    check("t6_mreq_busy", 64'(m_req), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("t6_rst");
    check("t6_stall", 64'(stall_req), 64'(1));
    slv_fix = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    push_txn(1'b0, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0);
    wait_ack(1'b0);
    @(posedge clk); #1;
    i_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("grant_q_drained", 64'(grant_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequential two-master arbiter that shares the single memory port of the minimal SOPC between the OpenMIPS instruction-fetch path and the load/store (MEM-stage) path. Each requester uses a hold-until-ack handshake. The arbiter serialises their transactions onto one slave port that also uses hold-until-ack. It raises a pipeline stall request while any access is outstanding, and it aborts slave transactions that hang past a timeout.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-select width is DATA_W/8
- TIMEOUT, 255, maximum cycles m_req may stay high without m_ack; must be ≥1
- MAX_D_RUN, 4, maximum consecutive data grants while i_req is pending; must be ≥1

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction read request, held until i_ack
- i_addr  in  ADDR_W  fetch address, stable while i_req=1
- i_rdata  out  DATA_W  fetched word, valid when i_ack=1
- i_ack  out  1  one-cycle completion pulse
- i_err  out  1  qualifies i_ack: the transaction timed out
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_sel  in  DATA_W/8  byte enables
- d_addr, d_wdata  in  ADDR_W, DATA_W  stable while d_req=1
- d_rdata  out  DATA_W  load data, valid when d_ack=1
- d_ack, d_err  out  1 each  same meaning as the i_ versions
- m_req  out  1  slave request, held until m_ack or abort
- m_we, m_sel, m_addr, m_wdata  out  1, DATA_W/8, ADDR_W, DATA_W  registered copies of the granted request
- m_rdata  in  DATA_W  slave read data, sampled when m_ack=1
- m_ack  in  1  slave completion, one cycle
- stall_req  out  1  combinational: (i_req & ~i_ack) | (d_req & ~d_ack)

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- Grant rule in IDLE:
  - If only one request is high, grant it.
  - If both are high, grant D, unless d_run == MAX_D_RUN; in that case grant I.
- Effect of a grant:
  - Latch the request fields into the m_* registers.
  - m_req goes to 1 on the same edge.
  - Next state is BUSY_I or BUSY_D.
- d_run counter:
  - Increments on each D grant made while i_req=1, saturating at MAX_D_RUN.
  - Clears on any I grant.
  - Clears on a D grant made while i_req=0.
- BUSY_x, on the edge where m_ack=1:
  - m_req goes to 0.
  - x_rdata takes m_rdata; it takes 0 for a write.
  - x_ack goes to 1 and x_err goes to 0.
  - Next state is RESP.
- BUSY_x timeout: tmo counts cycles in BUSY_x. When tmo reaches TIMEOUT−1 and m_ack=0:
  - m_req goes to 0 (abort).
  - x_ack goes to 1 and x_err goes to 1.
  - x_rdata goes to 0.
  - Next state is RESP.
- m_ack together with the final timeout cycle: m_ack wins and the transaction completes normally.
- RESP lasts exactly one cycle:
  - The ack pulse is visible.
  - No grant is made, because the requester's req is still high in this cycle.
  - x_ack and x_err clear to 0.
  - Next state is IDLE.
- m_ack received in IDLE or RESP is ignored.
- i_rdata and d_rdata hold their value until the next completion on that port.
- m_* fields hold the last granted values while idle; only m_req qualifies them.

## Timing
- Reset (async, immediate) clears:
  - state to IDLE
  - m_req, m_we, m_sel, m_addr, m_wdata to 0
  - i_ack, i_err, d_ack, d_err to 0
  - i_rdata, d_rdata to 0
  - d_run and tmo to 0
- stall_req follows its inputs combinationally.
- Reset during BUSY_x drops m_req immediately; no ack is issued.
- Latency, with request rising in cycle 0, the arbiter idle, and the slave acking k cycles after m_req rises (k ≥ 0 means m_ack is high in m_req cycle k):
  - m_req is high from cycle 1.
  - x_ack is high in cycle 2+k.
  - The arbiter is back in IDLE in cycle 3+k.
  - Minimum turnaround per transaction is 3 cycles.
- A request dropped before its ack is a protocol violation. The arbiter completes the slave access anyway and still pulses ack.

## Test plan
- Single fetch: i_req=1, i_addr=0x0000_0004, slave acks with m_rdata=0x3401_1100 when k=0 → m_req high in cycle 1 only, i_ack and i_rdata=0x3401_1100 in cycle 2, stall_req=0 from cycle 3.
- Simultaneous requests: i_req and d_req both high in cycle 0, d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF, d_sel=4'hF → D is served first with m_we=1 and m_wdata=0xDEAD_BEEF; I is granted in the IDLE cycle that follows RESP; d_rdata=0.
- Starvation guard, MAX_D_RUN=4: d_req and i_req held high continuously, with d_req re-asserted after each d_ack → exactly 4 D grants, then 1 I grant, then D again.
- Timeout, TIMEOUT=8: d_req read with m_ack held low → m_req high for exactly 8 cycles, then d_ack=1 with d_err=1 and d_rdata=0; the next transaction proceeds normally.
- Boundary: m_ack=1 in the 8th BUSY cycle with TIMEOUT=8 → normal ack, err=0. Spurious m_ack in IDLE → no ack output and no state change.
- Reset mid-BUSY: assert rst while m_req=1 → all outputs 0 without waiting for clk; after release, the pending i_req is re-granted from IDLE.
